// File: rtl/cpu_pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pic_pkg
//  Description : Shared types and constants for the XT 8259A-compatible PIC:
//                init-state encoding, ICW1/OCW bit positions, OCW2 EOI
//                command codes and the spurious interrupt level.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pic_pkg;

    // Initialisation sequence position; READY is the only operational state.
    typedef enum logic [1:0] {
        INIT_READY = 2'd0,
        INIT_ICW2  = 2'd1,
        INIT_ICW3  = 2'd2,
        INIT_ICW4  = 2'd3
    } init_state_e;

    // Data-bus bit positions for command decode.
    localparam int unsigned c_BIT_ICW1 = 4;  // A0=0, D4=1 selects ICW1
    localparam int unsigned c_BIT_OCW3 = 3;  // A0=0, D4=0, D3=1 selects OCW3
    localparam int unsigned c_BIT_RR   = 1;  // OCW3 read-register enable
    localparam int unsigned c_BIT_RIS  = 0;  // OCW3 1=ISR, 0=IRR
    localparam int unsigned c_BIT_SNGL = 1;  // ICW1 single-PIC flag
    localparam int unsigned c_BIT_IC4  = 0;  // ICW1 ICW4-needed flag

    // OCW2 command field D[7:5].
    localparam logic [2:0] c_EOI_NS = 3'b001;
    localparam logic [2:0] c_EOI_SP = 3'b011;

    // Level reported when an acknowledge finds nothing to serve.
    localparam logic [2:0] c_SPURIOUS_LEVEL = 3'd7;

endpackage
`default_nettype wire

// File: rtl/cpu_pic_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pic_if
//  Description : CPU-side bus of the PIC: decoded I/O strobes, address bit 0,
//                write data, interrupt acknowledge, IRQ lines, and the
//                registered read/vector data and INTR outputs.
//                master : bus-cycle decoder / IRQ sources side
//                slave  : PIC side
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_pic_if;
    logic       iSel;     // chip select, qualifies iRd/iWr
    logic       iA0;      // address bit 0
    logic       iRd;      // one-cycle read strobe
    logic       iWr;      // one-cycle write strobe
    logic       iIntAck;  // one-cycle acknowledge strobe, not qualified by iSel
    logic [7:0] iData;    // write data
    logic [7:0] oData;    // read / vector data
    logic [7:0] iIrq;     // interrupt request lines
    logic       oIntr;    // interrupt request to CPU

    modport master (
        output iSel, iA0, iRd, iWr, iIntAck, iData, iIrq,
        input  oData, oIntr
    );

    modport slave (
        input  iSel, iA0, iRd, iWr, iIntAck, iData, iIrq,
        output oData, oIntr
    );
endinterface
`default_nettype wire

// File: rtl/cpu_pic_prio.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pic_prio
//  Description : 8-bit fixed-priority encoder, lowest set index wins.
//  Ports       : req_i   - request vector
//                valid_o - any request set
//                idx_o   - index of lowest set request (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_pic_prio (
    input  logic [7:0] req_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = 3'd0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_pic.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pic
//  Description : XT-only 8259A-compatible interrupt controller. Single PIC,
//                edge-triggered, fixed priority (IR0 highest), no cascade,
//                rotation, auto-EOI or poll mode.
//  Ports       : iClk, iRst   - clock, synchronous active-high reset
//                bus (slave)  - strobes, A0, data, IRQ lines, oData, oIntr
//  Parameters  : VECTOR_BASE  - vector base used until ICW2 is written
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_pic
    import cpu_pic_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic        iClk,
    input  logic        iRst,
    cpu_pic_if.slave    bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]  irr_q,      irr_d;
    logic [7:0]  isr_q,      isr_d;
    logic [7:0]  imr_q,      imr_d;
    logic [4:0]  base_q,     base_d;
    logic [7:0]  irq_prev_q;
    logic        read_isr_q, read_isr_d;
    init_state_e init_q,     init_d;
    logic        sngl_q,     sngl_d;
    logic        ic4_q,      ic4_d;
    logic        ack_phase_q, ack_phase_d;
    logic [2:0]  vec_q,      vec_d;
    logic [7:0]  data_q,     data_d;
    logic        intr_q,     intr_d;

    // ------------------------------------------------------------------
    // Priority resolution
    // ------------------------------------------------------------------
    logic [7:0] w_pend;
    logic       w_hp_valid, w_hs_valid, w_qualify;
    logic [2:0] w_hp, w_hs;

    assign w_pend = irr_q & ~imr_q;

    cpu_pic_prio u_prio_pend (.req_i(w_pend), .valid_o(w_hp_valid), .idx_o(w_hp));
    cpu_pic_prio u_prio_isr  (.req_i(isr_q),  .valid_o(w_hs_valid), .idx_o(w_hs));

    // A pending request is only served if it outranks everything in service.
    assign w_qualify = w_hp_valid && (!w_hs_valid || (w_hp < w_hs));

    logic       w_rd, w_wr;
    logic [7:0] w_edge;

    assign w_rd   = bus.iSel & bus.iRd;
    assign w_wr   = bus.iSel & bus.iWr;
    assign w_edge = bus.iIrq & ~irq_prev_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        irr_d       = irr_q;
        isr_d       = isr_q;
        imr_d       = imr_q;
        base_d      = base_q;
        read_isr_d  = read_isr_q;
        init_d      = init_q;
        sngl_d      = sngl_q;
        ic4_d       = ic4_q;
        ack_phase_d = ack_phase_q;
        vec_d       = vec_q;
        data_d      = data_q;
        intr_d      = (init_q == INIT_READY) && w_qualify;

        if (w_rd) begin
            if (bus.iA0)        data_d = imr_q;
            else if (read_isr_q) data_d = isr_q;
            else                data_d = irr_q;
        end

        // Acknowledge is evaluated before writes so that an ICW1 in the
        // same cycle overrides the phase toggle and the ISR update.
        if (bus.iIntAck) begin
            if (!ack_phase_q) begin
                if (w_qualify) begin
                    vec_d        = w_hp;
                    isr_d[w_hp]  = 1'b1;
                    irr_d[w_hp]  = 1'b0;
                end else begin
                    vec_d = c_SPURIOUS_LEVEL;
                end
                data_d      = 8'hFF;
                ack_phase_d = 1'b1;
            end else begin
                data_d      = {base_q, vec_q};
                ack_phase_d = 1'b0;
            end
        end

        if (w_wr) begin
            if (!bus.iA0 && bus.iData[c_BIT_ICW1]) begin
                imr_d       = 8'h00;
                isr_d       = 8'h00;
                irr_d       = 8'h00;
                ack_phase_d = 1'b0;
                sngl_d      = bus.iData[c_BIT_SNGL];
                ic4_d       = bus.iData[c_BIT_IC4];
                read_isr_d  = 1'b0;
                init_d      = INIT_ICW2;
            end else begin
                case (init_q)
                    INIT_ICW2: begin
                        if (bus.iA0) begin
                            base_d = bus.iData[7:3];
                            if (!sngl_q)    init_d = INIT_ICW3;
                            else if (ic4_q) init_d = INIT_ICW4;
                            else            init_d = INIT_READY;
                        end
                    end
                    INIT_ICW3: begin
                        if (bus.iA0) init_d = ic4_q ? INIT_ICW4 : INIT_READY;
                    end
                    INIT_ICW4: begin
                        if (bus.iA0) init_d = INIT_READY;
                    end
                    default: begin
                        if (bus.iA0) begin
                            imr_d = bus.iData;
                        end else if (!bus.iData[c_BIT_OCW3]) begin
                            if (bus.iData[7:5] == c_EOI_NS) begin
                                if (w_hs_valid) isr_d[w_hs] = 1'b0;
                            end else if (bus.iData[7:5] == c_EOI_SP) begin
                                isr_d[bus.iData[2:0]] = 1'b0;
                            end
                        end else if (bus.iData[c_BIT_RR]) begin
                            read_isr_d = bus.iData[c_BIT_RIS];
                        end
                    end
                endcase
            end
        end

        // A new edge always lands, even over a same-cycle clear.
        irr_d = irr_d | w_edge;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            imr_q       <= 8'hFF;
            base_q      <= VECTOR_BASE[7:3];
            irq_prev_q  <= 8'hFF;  // lines already high at reset do not fire
            read_isr_q  <= 1'b0;
            init_q      <= INIT_READY;
            sngl_q      <= 1'b0;
            ic4_q       <= 1'b0;
            ack_phase_q <= 1'b0;
            vec_q       <= 3'd0;
            data_q      <= 8'h00;
            intr_q      <= 1'b0;
        end else begin
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            base_q      <= base_d;
            irq_prev_q  <= bus.iIrq;
            read_isr_q  <= read_isr_d;
            init_q      <= init_d;
            sngl_q      <= sngl_d;
            ic4_q       <= ic4_d;
            ack_phase_q <= ack_phase_d;
            vec_q       <= vec_d;
            data_q      <= data_d;
            intr_q      <= intr_d;
        end
    end

    assign bus.oData = data_q;
    assign bus.oIntr = intr_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_pic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_pic
//  Description : Self-checking bench for cpu_pic: directed scenarios plus a
//                randomized run against a behavioural model of the PIC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_pic;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_pic_if bus ();

    cpu_pic #(.VECTOR_BASE(8'h08)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] cur_irq = 8'h00;

    // ---------------- behavioural model ----------------
    logic [7:0] m_irr, m_isr, m_imr, m_base, m_prev, m_data;
    logic       m_rsel, m_phase, m_sngl, m_ic4, m_intr;
    int         m_st;    // 0 ready, 1 expect ICW2, 2 expect ICW3, 3 expect ICW4
    int         m_vec;

    // Lowest set bit index, 8 when empty.
    function automatic int lowest(input logic [7:0] x);
        for (int i = 0; i < 8; i++) if (x[i]) return i;
        return 8;
    endfunction

    task automatic model_reset();
        m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_base = 8'h08; m_prev = 8'hFF;
        m_data = 0; m_rsel = 0; m_phase = 0; m_sngl = 0; m_ic4 = 0;
        m_intr = 0; m_st = 0; m_vec = 0;
    endtask

    task automatic model_step(input logic rd, input logic wr, input logic a0,
                              input logic ack, input logic [7:0] d, input logic [7:0] irq);
        int hp, hs;
        hp = lowest(m_irr & ~m_imr);
        hs = lowest(m_isr);
        m_intr = (m_st == 0) && (hp < hs);
        if (rd) m_data = a0 ? m_imr : (m_rsel ? m_isr : m_irr);
        if (ack) begin
            if (!m_phase) begin
                if (hp < hs) begin
                    m_vec = hp; m_isr[hp] = 1'b1; m_irr[hp] = 1'b0;
                end else m_vec = 7;
                m_data = 8'hFF; m_phase = 1;
            end else begin
                m_data = 8'((m_base & 8'hF8) + m_vec); m_phase = 0;
            end
        end
        if (wr) begin
            if (!a0 && d[4]) begin
                m_imr = 0; m_isr = 0; m_irr = 0; m_phase = 0;
                m_sngl = d[1]; m_ic4 = d[0]; m_rsel = 0; m_st = 1;
            end else if (m_st == 1) begin
                if (a0) begin
                    m_base = d & 8'hF8;
                    m_st = !m_sngl ? 2 : (m_ic4 ? 3 : 0);
                end
            end else if (m_st == 2) begin
                if (a0) m_st = m_ic4 ? 3 : 0;
            end else if (m_st == 3) begin
                if (a0) m_st = 0;
            end else if (a0) begin
                m_imr = d;
            end else if (!d[3]) begin
                if (d[7:5] == 3'b001 && hs < 8) m_isr[hs] = 1'b0;
                else if (d[7:5] == 3'b011)     m_isr[d[2:0]] = 1'b0;
            end else if (d[1]) begin
                m_rsel = d[0];
            end
        end
        m_irr  = m_irr | (irq & ~m_prev);
        m_prev = irq;
    endtask

    // ---------------- bus driving ----------------
    task automatic cyc(input logic rd, input logic wr, input logic a0,
                       input logic ack, input logic [7:0] d);
        @(negedge clk);
        bus.iSel = rd | wr; bus.iRd = rd; bus.iWr = wr; bus.iA0 = a0;
        bus.iIntAck = ack; bus.iData = d; bus.iIrq = cur_irq;
        model_step(rd, wr, a0, ack, d, cur_irq);
        @(posedge clk); #1;
        bus.iSel = 0; bus.iRd = 0; bus.iWr = 0; bus.iIntAck = 0;
    endtask

    task automatic idle();                          cyc(0, 0, 0, 0, 8'h00); endtask
    task automatic wr_reg(input logic a0, input logic [7:0] d); cyc(0, 1, a0, 0, d); endtask
    task automatic rd_reg(input logic a0);          cyc(1, 0, a0, 0, 8'h00); endtask
    task automatic ack();                           cyc(0, 0, 0, 1, 8'h00); endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; cur_irq = 0; bus.iIrq = 0;
        bus.iSel = 0; bus.iRd = 0; bus.iWr = 0; bus.iIntAck = 0; bus.iA0 = 0; bus.iData = 0;
        @(posedge clk); #1; @(posedge clk); #1;
        @(negedge clk); rst = 0;
        model_reset();
        idle();
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        cur_irq = m; idle(); cur_irq = 0; idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.oData !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.oData); end
        n_cmp++; if (bus.oIntr !== 1'b0)  begin n_bad++; $display("FAIL reset_intr: got %b want 0", bus.oIntr); end
        rd_reg(1);
        n_cmp++; if (bus.oData !== 8'hFF) begin n_bad++; $display("FAIL reset_imr: got %h want FF", bus.oData); end
    endtask

    task automatic test_unmask();
        pulse_irq(8'h01); idle();
        n_cmp++; if (bus.oIntr !== 1'b0) begin n_bad++; $display("FAIL masked_intr: got %b want 0", bus.oIntr); end
        wr_reg(1, 8'hFE); idle();
        n_cmp++; if (bus.oIntr !== 1'b1) begin n_bad++; $display("FAIL unmask_intr: got %b want 1", bus.oIntr); end
        ack();
        n_cmp++; if (bus.oData !== 8'hFF) begin n_bad++; $display("FAIL unmask_ack1: got %h want FF", bus.oData); end
        ack();
        n_cmp++; if (bus.oData !== 8'h08) begin n_bad++; $display("FAIL unmask_vec: got %h want 08", bus.oData); end
        rd_reg(0);
        n_cmp++; if (bus.oData !== 8'h00) begin n_bad++; $display("FAIL unmask_irr: got %h want 00", bus.oData); end
        wr_reg(0, 8'h0B); rd_reg(0);
        n_cmp++; if (bus.oData !== 8'h01) begin n_bad++; $display("FAIL unmask_isr: got %h want 01", bus.oData); end
    endtask

    task automatic test_init();
        do_reset();
        wr_reg(0, 8'h13);
        wr_reg(1, 8'h08);
        wr_reg(1, 8'h09);
        rd_reg(1);
        n_cmp++; if (bus.oData !== 8'h00) begin n_bad++; $display("FAIL init_imr: got %h want 00", bus.oData); end
        n_cmp++; if (bus.oIntr !== 1'b0)  begin n_bad++; $display("FAIL init_intr: got %b want 0", bus.oIntr); end
    endtask

    task automatic test_priority();
        pulse_irq(8'h0A);
        n_cmp++; if (bus.oIntr !== 1'b1) begin n_bad++; $display("FAIL prio_intr: got %b want 1", bus.oIntr); end
        ack(); ack();
        n_cmp++; if (bus.oData !== 8'h09) begin n_bad++; $display("FAIL prio_vec: got %h want 09", bus.oData); end
        pulse_irq(8'h10); idle();
        n_cmp++; if (bus.oIntr !== 1'b0) begin n_bad++; $display("FAIL nested_block: got %b want 0", bus.oIntr); end
        wr_reg(0, 8'h20);
        wr_reg(0, 8'h0B); rd_reg(0);
        n_cmp++; if (bus.oData !== 8'h00) begin n_bad++; $display("FAIL eoi_ns_isr: got %h want 00", bus.oData); end
        n_cmp++; if (bus.oIntr !== 1'b1)  begin n_bad++; $display("FAIL eoi_intr: got %b want 1", bus.oIntr); end
        ack(); ack();
        n_cmp++; if (bus.oData !== 8'h0B) begin n_bad++; $display("FAIL prio_vec2: got %h want 0B", bus.oData); end
    endtask

    task automatic test_spurious();
        ack();
        n_cmp++; if (bus.oData !== 8'hFF) begin n_bad++; $display("FAIL spur_ack1: got %h want FF", bus.oData); end
        ack();
        n_cmp++; if (bus.oData !== 8'h0F) begin n_bad++; $display("FAIL spur_vec: got %h want 0F", bus.oData); end
        rd_reg(0);
        n_cmp++; if (bus.oData !== 8'h08) begin n_bad++; $display("FAIL spur_isr: got %h want 08", bus.oData); end
    endtask

    task automatic test_ocw3_eoi();
        wr_reg(0, 8'h0A); rd_reg(0);
        n_cmp++; if (bus.oData !== 8'h10) begin n_bad++; $display("FAIL ocw3_irr: got %h want 10", bus.oData); end
        wr_reg(0, 8'h0B); rd_reg(0);
        n_cmp++; if (bus.oData !== 8'h08) begin n_bad++; $display("FAIL ocw3_isr: got %h want 08", bus.oData); end
        wr_reg(0, 8'h63); rd_reg(0);
        n_cmp++; if (bus.oData !== 8'h00) begin n_bad++; $display("FAIL eoi_sp_isr: got %h want 00", bus.oData); end
        idle();
        n_cmp++; if (bus.oIntr !== 1'b1) begin n_bad++; $display("FAIL eoi_sp_intr: got %b want 1", bus.oIntr); end
    endtask

    task automatic test_reset_mid_ack();
        ack();
        n_cmp++; if (bus.oData !== 8'hFF) begin n_bad++; $display("FAIL mid_ack1: got %h want FF", bus.oData); end
        do_reset();
        n_cmp++; if (bus.oIntr !== 1'b0) begin n_bad++; $display("FAIL mid_intr: got %b want 0", bus.oIntr); end
        ack();
        n_cmp++; if (bus.oData !== 8'hFF) begin n_bad++; $display("FAIL mid_restart: got %h want FF", bus.oData); end
        rd_reg(1);
        n_cmp++; if (bus.oData !== 8'hFF) begin n_bad++; $display("FAIL mid_imr: got %h want FF", bus.oData); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_reg(0, 8'h13); wr_reg(1, 8'h08); wr_reg(1, 8'h09);
        pulse_irq(8'h04);
        ack();
        cyc(0, 1, 0, 1, 8'h13);  // second ack together with ICW1
        n_cmp++; if (bus.oData !== 8'h0A) begin n_bad++; $display("FAIL simul_vec: got %h want 0A", bus.oData); end
        wr_reg(1, 8'h08); wr_reg(1, 8'h09);
        ack();
        n_cmp++; if (bus.oData !== 8'hFF) begin n_bad++; $display("FAIL simul_phase: got %h want FF", bus.oData); end
        ack();
        n_cmp++; if (bus.oData !== 8'h0F) begin n_bad++; $display("FAIL simul_spur: got %h want 0F", bus.oData); end
        pulse_irq(8'h20);
        ack();
        wr_reg(1, 8'hFF);
        ack();
        n_cmp++; if (bus.oData !== 8'h0D) begin n_bad++; $display("FAIL vec_kept: got %h want 0D", bus.oData); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       a0;
        int         op;
        do_reset();
        wr_reg(0, 8'h13); wr_reg(1, 8'h08); wr_reg(1, 8'h09);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ (8'h01 << $urandom_range(0, 7));
            a0 = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (a0 && $urandom_range(0, 3) != 0) d = d & 8'h3F;  // keep IRQs mostly unmasked
            if (!a0 && $urandom_range(0, 9) != 0) d[4] = 1'b0;
            if (!a0 && !d[4] && !d[3] && $urandom_range(0, 1) == 1)
                d[7:5] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b011;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: idle();
                3:       rd_reg(a0);
                4, 5:    wr_reg(a0, d);
                6, 7, 8: ack();
                default: cyc(0, 1, a0, 1, d);
            endcase
            n_cmp++; if (bus.oData !== m_data) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, bus.oData, m_data); end
            n_cmp++; if (bus.oIntr !== m_intr) begin n_bad++; $display("FAIL rand_intr[%0d]: got %b want %b", n, bus.oIntr, m_intr); end
        end
    endtask

    initial begin
        bus.iSel = 0; bus.iRd = 0; bus.iWr = 0; bus.iIntAck = 0;
        bus.iA0 = 0; bus.iData = 0; bus.iIrq = 0;
        model_reset();
        test_reset();
        test_unmask();
        test_init();
        test_priority();
        test_spurious();
        test_ocw3_eoi();
        test_reset_mid_ack();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
